// File: rtl/idecode_pkg.sv
// Shared decode types, opcode constants and the ARM32 instruction decode function.
// Latency: combinational (function only).
// Backpressure: none; pure decode. IDECODE_LDST_EN enables class-01 load/store decode.
package idecode_pkg;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [6:0] OP_B    = 7'b1000000;
    localparam logic [6:0] OP_BL   = 7'b1000100;
    localparam logic [6:0] OP_BX   = 7'b1000001;
    localparam logic [6:0] OP_BLX  = 7'b1000101;

    // ALU base selects operand form; offset selects the operation.
    localparam logic [6:0] ALU_BASE_REG = 7'b0000000;
    localparam logic [6:0] ALU_BASE_IMM = 7'b0010000;
    localparam logic [6:0] ALU_BASE_RSH = 7'b0100000;
    localparam logic [6:0] ALU_OFS_ADD  = 7'd0;
    localparam logic [6:0] ALU_OFS_SUB  = 7'd1;
    localparam logic [6:0] ALU_OFS_CMP  = 7'd2;
    localparam logic [6:0] ALU_OFS_AND  = 7'd3;
    localparam logic [6:0] ALU_OFS_ORR  = 7'd4;
    localparam logic [6:0] ALU_OFS_EOR  = 7'd5;
    localparam logic [6:0] ALU_OFS_MOV  = 7'd8;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    typedef struct packed {
        logic [3:0]  cond;
        logic [6:0]  opcode;
        logic        en_status;
        logic        halt;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rm;
        logic [1:0]  shift_op;
        logic [4:0]  imm5;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } decoded_t;

    // Raw fields are always extracted; only opcode/halt depend on the class.
    // Anything not explicitly recognised falls through to OP_HALT with halt set.
    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t   d;
        logic [6:0] base;
        logic [6:0] ofs;
        logic       ofs_ok;
        d.cond      = instr[31:28];
        d.en_status = instr[20];
        d.rn        = instr[19:16];
        d.rd        = instr[15:12];
        d.rs        = instr[11:8];
        d.rm        = instr[3:0];
        d.shift_op  = instr[7:6];
        d.imm5      = instr[4:0];
        d.imm12     = instr[11:0];
        d.imm24     = instr[23:0];
        d.opcode    = OP_HALT;
        d.halt      = 1'b1;
        base        = ALU_BASE_REG;
        ofs         = ALU_OFS_ADD;
        ofs_ok      = 1'b1;
        case (instr[27:26])
            2'b00: begin
                if (instr[27:21] == 7'b0011001) begin
                    d.opcode = OP_NOP;
                    d.halt   = 1'b0;
                end else if (instr[27:21] == 7'b0001000) begin
                    d.opcode = OP_HALT;
                    d.halt   = 1'b1;
                end else if (instr[27:21] == 7'b0001001) begin
                    d.opcode = instr[5] ? OP_BLX : OP_BX;
                    d.halt   = 1'b0;
                end else begin
                    if (instr[25])     base = ALU_BASE_IMM;
                    else if (instr[4]) base = ALU_BASE_RSH;
                    case (instr[24:21])
                        4'b0100: ofs = ALU_OFS_ADD;
                        4'b0010: ofs = ALU_OFS_SUB;
                        4'b1010: ofs = ALU_OFS_CMP;
                        4'b0000: ofs = ALU_OFS_AND;
                        4'b1100: ofs = ALU_OFS_ORR;
                        4'b0001: ofs = ALU_OFS_EOR;
                        4'b1101: ofs = ALU_OFS_MOV;
                        default: ofs_ok = 1'b0;
                    endcase
                    if (ofs_ok) begin
                        d.opcode = base + ofs;
                        d.halt   = 1'b0;
                    end
                end
            end
            2'b10: begin
                if (instr[25:24] == 2'b10) begin
                    d.opcode = OP_B;
                    d.halt   = 1'b0;
                end else if (instr[25:24] == 2'b11) begin
                    d.opcode = OP_BL;
                    d.halt   = 1'b0;
                end
            end
`ifdef IDECODE_LDST_EN
            2'b01: begin
                d.opcode = {3'b101, instr[24:21]};
                d.halt   = 1'b0;
            end
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/idecode_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count, flush and arbitrary-depth pointer wrap.
// Latency: write at edge N is readable after edge N; read data is the head combinationally.
// Backpressure: caller must not push when full or pop when empty; flush beats push/pop.
module idecode_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     wr_data,
    input  logic             pop,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    // Storage write; contents need no reset because emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/idecode_queue.sv
// ARM32 decode stage: decodes fetch words and buffers them in a DEPTH-entry FIFO; sticky HALT.
// Latency: 1 cycle from push to out_valid; no same-cycle pass-through.
// Backpressure: in_ready low when full, HALTED, flushing or in reset. Build option: IDECODE_LDST_EN.
module idecode_queue
    import idecode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [3:0]       out_cond,
    output logic [6:0]       out_opcode,
    output logic             out_en_status,
    output logic             out_halt,
    output logic [3:0]       out_rn,
    output logic [3:0]       out_rd,
    output logic [3:0]       out_rs,
    output logic [3:0]       out_rm,
    output logic [1:0]       out_shift_op,
    output logic [4:0]       out_imm5,
    output logic [11:0]      out_imm12,
    output logic [23:0]      out_imm24,
    output logic [CNT_W-1:0] count
);
    localparam int W = PC_W + $bits(decoded_t);

    state_t          state;
    state_t          state_nxt;
    decoded_t        in_dec;
    decoded_t        head_dec;
    logic [PC_W-1:0] head_pc;
    logic [W-1:0]    rd_data;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign in_dec    = decode(in_instr);
    assign in_ready  = !rst && (state == ST_RUN) && !full && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !flush;

    idecode_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_data ({in_pc, in_dec}),
        .pop     (pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Zero the head view while empty so stale storage never leaks to the consumer.
    assign {head_pc, head_dec} = out_valid ? rd_data : '0;

    assign out_pc        = head_pc;
    assign out_cond      = head_dec.cond;
    assign out_opcode    = head_dec.opcode;
    assign out_en_status = head_dec.en_status;
    assign out_halt      = head_dec.halt;
    assign out_rn        = head_dec.rn;
    assign out_rd        = head_dec.rd;
    assign out_rs        = head_dec.rs;
    assign out_rm        = head_dec.rm;
    assign out_shift_op  = head_dec.shift_op;
    assign out_imm5      = head_dec.imm5;
    assign out_imm12     = head_dec.imm12;
    assign out_imm24     = head_dec.imm24;

    // RUN/HALTED state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Halt after enqueuing a halting entry; only flush (or reset) resumes.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else if ((state == ST_RUN) && push && in_dec.halt) begin
            state_nxt = ST_HALTED;
        end
    end

endmodule

// File: tb/tb_idecode_queue.sv
// Directed bench for idecode_queue (DEPTH=2, PC_W=32) with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full FIFO, HALTED hold, flush and mid-stream reset.
module tb_idecode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_cond;
    logic [6:0]  out_opcode;
    logic        out_en_status;
    logic        out_halt;
    logic [3:0]  out_rn;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs;
    logic [3:0]  out_rm;
    logic [1:0]  out_shift_op;
    logic [4:0]  out_imm5;
    logic [11:0] out_imm12;
    logic [23:0] out_imm24;
    logic [1:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    idecode_queue #(.DEPTH(2), .PC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_cond      (out_cond),
        .out_opcode    (out_opcode),
        .out_en_status (out_en_status),
        .out_halt      (out_halt),
        .out_rn        (out_rn),
        .out_rd        (out_rd),
        .out_rs        (out_rs),
        .out_rm        (out_rm),
        .out_shift_op  (out_shift_op),
        .out_imm5      (out_imm5),
        .out_imm12     (out_imm12),
        .out_imm24     (out_imm24),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready",  32'(in_ready),   32'd0);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_count",     32'(count),      32'd0);
        chk("rst_opcode",    32'(out_opcode), 32'd0);
        chk("rst_pc",        out_pc,          32'd0);
        chk("rst_imm24",     32'(out_imm24),  32'd0);

        rst = 1'b0; #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // ADD r1,r2,r3; no pass-through before the edge
        in_valid = 1'b1; in_instr = 32'hE0821003; in_pc = 32'h100; out_ready = 1'b1; #1;
        chk("no_passthru", 32'(out_valid), 32'd0);
        tick(); in_valid = 1'b0;
        chk("add_valid",  32'(out_valid),  32'd1);
        chk("add_opcode", 32'(out_opcode), 32'h00);
        chk("add_rn",     32'(out_rn),     32'd2);
        chk("add_rd",     32'(out_rd),     32'd1);
        chk("add_rm",     32'(out_rm),     32'd3);
        chk("add_cond",   32'(out_cond),   32'hE);
        chk("add_halt",   32'(out_halt),   32'd0);
        chk("add_pc",     out_pc,          32'h100);
        tick();
        chk("add_popped", 32'(out_valid), 32'd0);
        chk("empty_rn_zero", 32'(out_rn), 32'd0);

        // Fill DEPTH=2, third refused, drain in order (pointer wrap)
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hE2433001; in_pc = 32'h200; tick();
        in_instr = 32'hE0433001; in_pc = 32'h204; tick();
        in_instr = 32'hE0821003; in_pc = 32'h208; #1;
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count),    32'd2);
        tick();
        chk("full_hold_count", 32'(count), 32'd2);
        out_ready = 1'b1; #1;
        chk("no_bypass_ready", 32'(in_ready),   32'd0);
        chk("subi_pc",         out_pc,          32'h200);
        chk("subi_opcode",     32'(out_opcode), 32'h11);
        chk("subi_imm12",      32'(out_imm12),  32'h001);
        tick();
        chk("pop1_count",  32'(count),      32'd1);
        chk("pop1_ready",  32'(in_ready),   32'd1);
        chk("subr_pc",     out_pc,          32'h204);
        chk("subr_opcode", 32'(out_opcode), 32'h01);
        chk("subr_halt",   32'(out_halt),   32'd0);
        tick();
        chk("pushpop_count", 32'(count),      32'd1);
        chk("third_pc",      out_pc,          32'h208);
        chk("third_opcode",  32'(out_opcode), 32'h00);
        in_valid = 1'b0; #1;
        chk("subr_stays_run", 32'(in_ready), 32'd1);
        tick();
        chk("drained", 32'(count), 32'd0);

        // HALT pattern ([27:21]=0001000) then MOV imm which must be refused
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hE1000000; in_pc = 32'h300; tick();
        in_instr = 32'hE3A01005; in_pc = 32'h304; #1;
        chk("halted_ready",  32'(in_ready),   32'd0);
        chk("halt_flag",     32'(out_halt),   32'd1);
        chk("halt_opcode",   32'(out_opcode), 32'h01);
        chk("halt_count",    32'(count),      32'd1);
        tick(); tick();
        chk("mov_not_taken", 32'(count), 32'd1);
        chk("halt_head_pc",  out_pc,     32'h300);
        in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0; #1;
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready),  32'd1);

        // Flush beats simultaneous push and pop
        in_valid = 1'b1; in_instr = 32'hE0821003; in_pc = 32'h400; tick();
        chk("pre_flush_count", 32'(count), 32'd1);
        out_ready = 1'b1; flush = 1'b1; #1;
        chk("flush_cycle_ready", 32'(in_ready), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("flush_push_count", 32'(count),     32'd0);
        chk("flush_push_valid", 32'(out_valid), 32'd0);

        // Branch B
        in_valid = 1'b1; in_instr = 32'hEA000010; in_pc = 32'h410; tick();
        chk("b_opcode", 32'(out_opcode), 32'h40);
        chk("b_imm24",  32'(out_imm24),  32'h000010);
        chk("b_halt",   32'(out_halt),   32'd0);

        // Reset mid-stream
        in_instr = 32'hE2433001; in_pc = 32'h420; tick(); in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1; tick();
        chk("midrst_valid",  32'(out_valid),  32'd0);
        chk("midrst_count",  32'(count),      32'd0);
        chk("midrst_pc",     out_pc,          32'd0);
        chk("midrst_opcode", 32'(out_opcode), 32'd0);
        chk("midrst_ready",  32'(in_ready),   32'd0);
        rst = 1'b0; #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // LDR r2,[r1,#4]
        in_valid = 1'b1; in_instr = 32'hE5912004; in_pc = 32'h500; tick(); in_valid = 1'b0; #1;
        chk("ldr_imm12", 32'(out_imm12), 32'h004);
`ifdef IDECODE_LDST_EN
        chk("ldr_opcode", 32'(out_opcode), 32'h5C);
        chk("ldr_halt",   32'(out_halt),   32'd0);
        chk("ldr_ready",  32'(in_ready),   32'd1);
`else
        chk("ldr_opcode", 32'(out_opcode), 32'h01);
        chk("ldr_halt",   32'(out_halt),   32'd1);
        chk("ldr_ready",  32'(in_ready),   32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
